// File: rtl/dmem_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dmem_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_WR_WAIT,
    S_RD_RELAY,
    S_WR_RELAY
  } state_t;

  // Mask of the low 'bits' bits of a 32-bit word.
  function automatic int unsigned low_mask(input int unsigned bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  // Chunk offset within a line: the lowest offset_bits of the address.
  function automatic int unsigned addr_offset(input int unsigned addr,
                                              input int unsigned offset_bits);
    return addr & low_mask(offset_bits);
  endfunction

  // Line index: the index_bits directly above the offset.
  function automatic int unsigned addr_index(input int unsigned addr,
                                             input int unsigned offset_bits,
                                             input int unsigned index_bits);
    return (addr >> offset_bits) & low_mask(index_bits);
  endfunction

  // Tag: everything above index and offset; the caller truncates to its width.
  function automatic int unsigned addr_tag(input int unsigned addr,
                                           input int unsigned offset_bits,
                                           input int unsigned index_bits);
    return addr >> (offset_bits + index_bits);
  endfunction

endpackage

// File: rtl/dmem_cache_dm_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int PTR_BITS      = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [PTR_BITS-1:0]      ptr,
  output logic [NUM_CONSUMERS-1:0] grant,
  output logic [PTR_BITS-1:0]      grant_idx,
  output logic                     grant_valid
);

  int                  cand;
  logic [PTR_BITS-1:0] cand_idx;

  // Scan from ptr upward, wrapping, and take the first asserted request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand     = (int'(ptr) + i) % NUM_CONSUMERS;
      cand_idx = PTR_BITS'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_cache_dm.sv
// Direct-mapped write-through data cache shared by several LSUs in front of
// one global data-memory channel. Line fills are sequential single-word reads.
module dmem_cache_dm
  import dmem_cache_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int OFFSET_BITS   = 1,
  parameter int INDEX_BITS    = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CONSUMERS-1:0]               consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]               consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]               consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]               consumer_write_ready,
  output logic                                   mem_read_valid,
  output logic [ADDR_BITS-1:0]                   mem_read_address,
  input  logic                                   mem_read_ready,
  input  logic [DATA_BITS-1:0]                   mem_read_data,
  output logic                                   mem_write_valid,
  output logic [ADDR_BITS-1:0]                   mem_write_address,
  output logic [DATA_BITS-1:0]                   mem_write_data,
  input  logic                                   mem_write_ready,
  input  logic                                   invalidate,
  output logic [CNT_BITS-1:0]                    hit_count,
  output logic [CNT_BITS-1:0]                    miss_count
);

  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_CHUNKS = 2 ** OFFSET_BITS;
  localparam int NUM_LINES  = 2 ** INDEX_BITS;
  localparam int PTR_BITS   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [OFFSET_BITS-1:0] LAST_CHUNK = OFFSET_BITS'(NUM_CHUNKS - 1);
  localparam logic [PTR_BITS-1:0]    LAST_PTR   = PTR_BITS'(NUM_CONSUMERS - 1);

  state_t state, state_next;

  // Line storage.
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_BITS-1:0] data_mem [NUM_LINES][NUM_CHUNKS];

  // Latched request context.
  logic [PTR_BITS-1:0]      rr_ptr;
  logic [PTR_BITS-1:0]      owner;
  logic [NUM_CONSUMERS-1:0] owner_onehot;
  logic [ADDR_BITS-1:0]     req_addr;
  logic [DATA_BITS-1:0]     req_data;
  logic [DATA_BITS-1:0]     rd_data;
  logic [OFFSET_BITS-1:0]   fill_k;
  logic                     inval_pending;

  logic [TAG_BITS-1:0]      req_tag;
  logic [INDEX_BITS-1:0]    req_index;
  logic [OFFSET_BITS-1:0]   req_offset;

  // Arbitration and grant-cycle lookup.
  logic [NUM_CONSUMERS-1:0] grant;
  logic [PTR_BITS-1:0]      grant_idx;
  logic                     grant_valid;
  logic                     grant_is_read;
  logic [ADDR_BITS-1:0]     grant_addr;
  logic [TAG_BITS-1:0]      grant_tag;
  logic [INDEX_BITS-1:0]    grant_index;
  logic                     lookup_hit;

  logic                     take_grant;
  logic                     fill_beat;
  logic                     fill_last;
  logic                     write_done;
  logic                     write_hit;

  rr_arbiter #(
    .NUM_CONSUMERS (NUM_CONSUMERS),
    .PTR_BITS      (PTR_BITS)
  ) u_arb (
    .req         (consumer_read_valid | consumer_write_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_is_read = consumer_read_valid[grant_idx];
  assign grant_addr    = grant_is_read ? consumer_read_address[grant_idx]
                                       : consumer_write_address[grant_idx];
  assign grant_tag     = TAG_BITS'(addr_tag(32'(grant_addr), OFFSET_BITS, INDEX_BITS));
  assign grant_index   = INDEX_BITS'(addr_index(32'(grant_addr), OFFSET_BITS, INDEX_BITS));
  // The lookup sees the valid bits before any same-edge invalidate clears them.
  assign lookup_hit    = line_valid[grant_index] && (tag_mem[grant_index] == grant_tag);

  assign req_tag    = TAG_BITS'(addr_tag(32'(req_addr), OFFSET_BITS, INDEX_BITS));
  assign req_index  = INDEX_BITS'(addr_index(32'(req_addr), OFFSET_BITS, INDEX_BITS));
  assign req_offset = OFFSET_BITS'(addr_offset(32'(req_addr), OFFSET_BITS));

  assign take_grant = (state == S_IDLE) && grant_valid;
  assign fill_beat  = (state == S_FILL_WAIT) && mem_read_ready;
  assign fill_last  = fill_beat && (fill_k == LAST_CHUNK);
  assign write_done = (state == S_WR_WAIT) && mem_write_ready;
  assign write_hit  = line_valid[req_index] && (tag_mem[req_index] == req_tag);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (grant_valid) state_next = grant_is_read ? (lookup_hit ? S_HIT : S_FILL_REQ)
                                                               : S_WR_WAIT;
      S_HIT:       state_next = S_RD_RELAY;
      S_FILL_REQ:  state_next = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_read_ready) state_next = (fill_k == LAST_CHUNK) ? S_RD_RELAY : S_FILL_REQ;
      S_WR_WAIT:   if (mem_write_ready) state_next = S_WR_RELAY;
      S_RD_RELAY:  if (!consumer_read_valid[owner]) state_next = S_IDLE;
      S_WR_RELAY:  if (!consumer_write_valid[owner]) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state and the latched request context.
  always_comb begin
    mem_read_valid       = (state == S_FILL_WAIT);
    mem_read_address     = '0;
    mem_write_valid      = (state == S_WR_WAIT);
    mem_write_address    = '0;
    mem_write_data       = '0;
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    if (state == S_FILL_WAIT) mem_read_address = {req_tag, req_index, fill_k};
    if (state == S_WR_WAIT) begin
      mem_write_address = req_addr;
      mem_write_data    = req_data;
    end
    if (state == S_RD_RELAY) begin
      consumer_read_ready = owner_onehot;
      for (int i = 0; i < NUM_CONSUMERS; i++)
        if (owner_onehot[i]) consumer_read_data[i] = rd_data;
    end
    if (state == S_WR_RELAY) consumer_write_ready = owner_onehot;
  end

  // Request context, valid bits, read data register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      owner         <= '0;
      owner_onehot  <= '0;
      req_addr      <= '0;
      req_data      <= '0;
      rd_data       <= '0;
      fill_k        <= '0;
      inval_pending <= 1'b0;
      line_valid    <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      if (take_grant) begin
        owner         <= grant_idx;
        owner_onehot  <= grant;
        rr_ptr        <= (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
        req_addr      <= grant_addr;
        req_data      <= consumer_write_data[grant_idx];
        fill_k        <= '0;
        inval_pending <= 1'b0;
        if (grant_is_read) begin
          if (lookup_hit) hit_count  <= hit_count + 1'b1;
          else            miss_count <= miss_count + 1'b1;
        end
      end

      if (state == S_HIT) rd_data <= data_mem[req_index][req_offset];

      if (fill_beat) begin
        if (fill_k == LAST_CHUNK)
          // The final chunk is not in the array yet, so bypass it from the bus.
          rd_data <= (req_offset == LAST_CHUNK) ? mem_read_data : data_mem[req_index][req_offset];
        else
          fill_k <= fill_k + 1'b1;
      end

      if (invalidate) begin
        line_valid <= '0;
        if (state == S_FILL_REQ || state == S_FILL_WAIT) inval_pending <= 1'b1;
      end

      // An invalidate during the fill, or on its last beat, leaves the line invalid.
      if (fill_last && !inval_pending && !invalidate) line_valid[req_index] <= 1'b1;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    // NOTE: the arrays have no reset; the reset valid bits make their contents irrelevant.
    if (!reset) begin
      if (fill_beat) begin
        data_mem[req_index][fill_k] <= mem_read_data;
        if (fill_k == LAST_CHUNK) tag_mem[req_index] <= req_tag;
      end
      if (write_done && write_hit) data_mem[req_index][req_offset] <= req_data;
    end
  end

endmodule

// File: tb/tb_dmem_cache_dm.sv
// Directed self-checking bench for dmem_cache_dm with a one-cycle memory model.
module tb_dmem_cache_dm;

  localparam int TIMEOUT = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      consumer_read_valid = '0;
  logic [3:0][7:0] consumer_read_address = '0;
  logic [3:0]      consumer_read_ready;
  logic [3:0][7:0] consumer_read_data;
  logic [3:0]      consumer_write_valid = '0;
  logic [3:0][7:0] consumer_write_address = '0;
  logic [3:0][7:0] consumer_write_data = '0;
  logic [3:0]      consumer_write_ready;
  logic            mem_read_valid;
  logic [7:0]      mem_read_address;
  logic            mem_read_ready = 1'b0;
  logic [7:0]      mem_read_data = '0;
  logic            mem_write_valid;
  logic [7:0]      mem_write_address;
  logic [7:0]      mem_write_data;
  logic            mem_write_ready = 1'b0;
  logic            invalidate = 1'b0;
  logic [15:0]     hit_count;
  logic [15:0]     miss_count;

  logic [7:0] mem [256];
  logic       mem_hold = 1'b0;
  logic [7:0] rd_log[$];
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_cache_dm dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .invalidate             (invalidate),
    .hit_count              (hit_count),
    .miss_count             (miss_count)
  );

  // Memory model: answers each request with a one-cycle ready pulse, logs traffic.
  always @(negedge clk) begin
    if (reset) begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
    end else begin
      if (mem_read_ready) mem_read_ready = 1'b0;
      else if (mem_read_valid && !mem_hold) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem[mem_read_address];
        rd_log.push_back(mem_read_address);
      end
      if (mem_write_ready) mem_write_ready = 1'b0;
      else if (mem_write_valid) begin
        mem_write_ready = 1'b1;
        mem[mem_write_address] = mem_write_data;
        wr_addr_log.push_back(mem_write_address);
        wr_data_log.push_back(mem_write_data);
      end
    end
  end

  function automatic logic [7:0] rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 8'hxx;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] c, input logic [7:0] a,
                         output logic [7:0] d, output int cyc);
    consumer_read_address[c] = a;
    consumer_read_valid[c]   = 1'b1;
    cyc = 0;
    while (consumer_read_ready[c] !== 1'b1 && cyc < TIMEOUT) begin
      step();
      cyc++;
    end
    checks++;
    if (consumer_read_ready[c] !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout: consumer %0d addr %h no ready after %0d cycles", c, a, cyc);
    end
    d = consumer_read_data[c];
    consumer_read_valid[c] = 1'b0;
    step();
  endtask

  task automatic do_write(input logic [1:0] c, input logic [7:0] a, input logic [7:0] dt);
    int cyc;
    consumer_write_address[c] = a;
    consumer_write_data[c]    = dt;
    consumer_write_valid[c]   = 1'b1;
    cyc = 0;
    while (consumer_write_ready[c] !== 1'b1 && cyc < TIMEOUT) begin
      step();
      cyc++;
    end
    checks++;
    if (consumer_write_ready[c] !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout: consumer %0d addr %h no ready after %0d cycles", c, a, cyc);
    end
    consumer_write_valid[c] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid} !== 10'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b expected 0",
               {consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid});
    end
    checks++;
    if ({hit_count, miss_count} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: got hit %0d miss %0d expected 0 0", hit_count, miss_count);
    end
    checks++;
    if (consumer_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_read_data: got %h expected 0", consumer_read_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cold_read();
    logic [7:0] d;
    int cyc;
    rd_log.delete();
    do_read(2'd0, 8'h13, d, cyc);
    checks++;
    if (d !== 8'hBB) begin errors++; $display("FAIL cold_read_data: got %h expected bb", d); end
    checks++;
    if ({rd_at(0), rd_at(1)} !== 16'h1213 || rd_log.size() != 2) begin
      errors++;
      $display("FAIL cold_fill_addrs: got %0d reads %h %h expected 2 reads 12 13", rd_log.size(), rd_at(0), rd_at(1));
    end
    checks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL cold_counters: got hit %0d miss %0d expected 0 1", hit_count, miss_count);
    end
  endtask

  task automatic test_hit();
    logic [7:0] d;
    int cyc;
    rd_log.delete();
    do_read(2'd1, 8'h12, d, cyc);
    checks++;
    if (d !== 8'hAA) begin errors++; $display("FAIL hit_data: got %h expected aa", d); end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", cyc); end
    checks++;
    if (rd_log.size() != 0) begin errors++; $display("FAIL hit_mem_reads: got %0d expected 0", rd_log.size()); end
    checks++;
    if (hit_count !== 16'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", hit_count); end
  endtask

  task automatic test_write_through();
    logic [7:0] d;
    int cyc;
    wr_addr_log.delete();
    wr_data_log.delete();
    do_write(2'd2, 8'h12, 8'h55);
    checks++;
    if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 8'h12 || wr_data_log[0] !== 8'h55) begin
      errors++;
      $display("FAIL wr_hit_mem: got %0d writes expected one write 12/55", wr_addr_log.size());
    end
    rd_log.delete();
    do_read(2'd0, 8'h12, d, cyc);
    checks++;
    if (d !== 8'h55 || rd_log.size() != 0) begin
      errors++;
      $display("FAIL wr_hit_reread: got %h with %0d reads expected 55 with 0", d, rd_log.size());
    end
    checks++;
    if (hit_count !== 16'd2) begin errors++; $display("FAIL wr_hit_count: got %0d expected 2", hit_count); end
    do_write(2'd3, 8'h40, 8'h77);
    rd_log.delete();
    do_read(2'd3, 8'h40, d, cyc);
    checks++;
    if (d !== 8'h77) begin errors++; $display("FAIL wr_miss_read_data: got %h expected 77", d); end
    checks++;
    if (rd_log.size() != 2 || rd_at(0) !== 8'h40) begin
      errors++;
      $display("FAIL wr_miss_no_alloc: got %0d reads first %h expected 2 reads first 40", rd_log.size(), rd_at(0));
    end
    checks++;
    if (miss_count !== 16'd2) begin errors++; $display("FAIL wr_miss_count: got %0d expected 2", miss_count); end
    // Consumer 1 is granted last, which leaves the round-robin pointer at 2.
    do_read(2'd1, 8'h13, d, cyc);
    checks++;
    if (d !== 8'hBB) begin errors++; $display("FAIL ptr_setup_data: got %h expected bb", d); end
  endtask

  task automatic test_round_robin();
    int         exp_order [4] = '{2, 3, 0, 1};
    logic [7:0] exp_data  [4] = '{8'hBB, 8'h55, 8'h77, 8'h3A};
    int         n;
    int         idx;
    rd_log.delete();
    consumer_read_address = {8'h60, 8'h40, 8'h12, 8'h13};
    consumer_read_valid   = 4'hF;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (consumer_read_ready == 4'h0 && n < TIMEOUT) begin
        step();
        n++;
      end
      idx = -1;
      for (int i = 0; i < 4; i++) if (consumer_read_ready[i]) idx = i;
      checks++;
      if (idx != exp_order[k]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got consumer %0d expected %0d", k, idx, exp_order[k]);
      end
      if (idx >= 0) begin
        checks++;
        if (consumer_read_data[idx] !== exp_data[idx]) begin
          errors++;
          $display("FAIL rr_data_c%0d: got %h expected %h", idx, consumer_read_data[idx], exp_data[idx]);
        end
        consumer_read_valid[idx] = 1'b0;
        step();
      end
    end
    consumer_read_valid = '0;
    checks++;
    if (rd_log.size() != 2 || rd_at(0) !== 8'h60) begin
      errors++;
      $display("FAIL rr_mem_reads: got %0d reads first %h expected 2 first 60", rd_log.size(), rd_at(0));
    end
    checks++;
    if (hit_count !== 16'd6 || miss_count !== 16'd3) begin
      errors++;
      $display("FAIL rr_counters: got hit %0d miss %0d expected 6 3", hit_count, miss_count);
    end
  endtask

  task automatic test_alias();
    logic [7:0] d;
    int cyc;
    do_read(2'd0, 8'h12, d, cyc);
    rd_log.delete();
    do_read(2'd0, 8'h32, d, cyc);
    checks++;
    if (d !== 8'h68 || rd_log.size() != 2 || rd_at(0) !== 8'h32) begin
      errors++;
      $display("FAIL alias_miss: got %h with %0d reads first %h expected 68 with 2 first 32", d, rd_log.size(), rd_at(0));
    end
    rd_log.delete();
    do_read(2'd0, 8'h12, d, cyc);
    checks++;
    if (d !== 8'h55 || rd_log.size() != 2 || rd_at(0) !== 8'h12) begin
      errors++;
      $display("FAIL alias_reread: got %h with %0d reads first %h expected 55 with 2 first 12", d, rd_log.size(), rd_at(0));
    end
    checks++;
    if (hit_count !== 16'd7 || miss_count !== 16'd5) begin
      errors++;
      $display("FAIL alias_counters: got hit %0d miss %0d expected 7 5", hit_count, miss_count);
    end
  endtask

  task automatic test_invalidate();
    logic [7:0] d;
    int cyc;
    int n;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    rd_log.delete();
    consumer_read_address[0] = 8'h13;
    consumer_read_valid[0]   = 1'b1;
    n = 0;
    while (mem_read_valid !== 1'b1 && n < TIMEOUT) begin step(); n++; end
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    while (consumer_read_ready[0] !== 1'b1 && n < TIMEOUT) begin step(); n++; end
    checks++;
    if (consumer_read_ready[0] !== 1'b1 || consumer_read_data[0] !== 8'hBB) begin
      errors++;
      $display("FAIL inval_fill_data: got ready %b data %h expected 1 bb", consumer_read_ready[0], consumer_read_data[0]);
    end
    consumer_read_valid[0] = 1'b0;
    step();
    checks++;
    if (rd_log.size() != 2) begin errors++; $display("FAIL inval_idle_miss: got %0d reads expected 2", rd_log.size()); end
    rd_log.delete();
    do_read(2'd0, 8'h13, d, cyc);
    checks++;
    if (d !== 8'hBB || rd_log.size() != 2) begin
      errors++;
      $display("FAIL inval_reread: got %h with %0d reads expected bb with 2", d, rd_log.size());
    end
    checks++;
    if (hit_count !== 16'd7 || miss_count !== 16'd7) begin
      errors++;
      $display("FAIL inval_counters: got hit %0d miss %0d expected 7 7", hit_count, miss_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    int cyc;
    int n;
    mem_hold = 1'b1;
    consumer_read_address[0] = 8'h50;
    consumer_read_valid[0]   = 1'b1;
    n = 0;
    while (mem_read_valid !== 1'b1 && n < TIMEOUT) begin step(); n++; end
    step();
    checks++;
    if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", mem_read_valid); end
    reset = 1'b1;
    consumer_read_valid[0] = 1'b0;
    step();
    checks++;
    if (mem_read_valid !== 1'b0 || miss_count !== 16'd0 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_fill: got valid %b hit %0d miss %0d expected 0 0 0", mem_read_valid, hit_count, miss_count);
    end
    reset    = 1'b0;
    mem_hold = 1'b0;
    step();
    rd_log.delete();
    do_read(2'd0, 8'h13, d, cyc);
    checks++;
    if (d !== 8'hBB || rd_log.size() != 2 || miss_count !== 16'd1 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_miss: got %h reads %0d hit %0d miss %0d expected bb 2 0 1",
               d, rd_log.size(), hit_count, miss_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h12] = 8'hAA;
    mem[8'h13] = 8'hBB;
    @(negedge clk);
    test_reset();
    test_cold_read();
    test_hit();
    test_write_through();
    test_round_robin();
    test_alias();
    test_invalidate();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
